// File: rtl/tmds_dc_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_dc_encoder
//  Purpose  : DVI/HDMI TMDS channel encoder. A two-stage pipeline turns an
//             8-bit pixel byte (or a 2-bit control code during blanking) into
//             a 10-bit DC-balanced TMDS symbol. One instance per colour channel.
//  Ports    : clk_in      - pixel clock
//             rst_n_in    - asynchronous active-low reset
//             data_in     - pixel byte, used when ve_in=1
//             control_in  - {C1,C0}, used when ve_in=0
//             ve_in       - video enable (1=active video, 0=blanking)
//             tmds_out    - encoded symbol, bit 0 transmitted first
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_dc_encoder #(
    parameter int CNT_W = 5
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out
);

    localparam logic [9:0] c_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] c_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] c_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] c_CTRL_11 = 10'b1010101011;
    localparam logic signed [CNT_W-1:0] c_TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] c_EIGHT = CNT_W'(8);

    // ------------------------------------------------------------------
    // Stage 1: transition minimisation (8b -> 9b q_m)
    // ------------------------------------------------------------------
    logic [3:0] w_din_ones;
    logic       w_use_xnor;
    logic [8:0] w_qm;

    always_comb begin
        w_din_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_din_ones = w_din_ones + {3'b000, data_in[i]};
        end
        // XNOR chaining wins for byte values with many ones; the tie at
        // four ones is broken on bit 0 so the choice is deterministic.
        w_use_xnor = (w_din_ones > 4'd4) || ((w_din_ones == 4'd4) && !data_in[0]);
        w_qm       = '0;
        w_qm[0]    = data_in[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ data_in[i]) : (w_qm[i-1] ^ data_in[i]);
        end
        w_qm[8] = ~w_use_xnor;
    end

    logic       r_s1_valid;
    logic       r_s1_ve;
    logic [1:0] r_s1_ctrl;
    logic [8:0] r_s1_qm;

    // r_s1_valid keeps the output at 10'h000 until stage 1 holds a real
    // post-reset sample, so the first symbol appears two edges after release.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_ve    <= 1'b0;
            r_s1_ctrl  <= 2'b00;
            r_s1_qm    <= '0;
        end else begin
            r_s1_valid <= 1'b1;
            r_s1_ve    <= ve_in;
            r_s1_ctrl  <= control_in;
            r_s1_qm    <= w_qm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: DC balance / control token insertion
    // ------------------------------------------------------------------
    logic signed [CNT_W-1:0] r_cnt;
    logic [9:0]              r_tmds;

    logic [3:0]              w_qm_ones;
    logic signed [CNT_W-1:0] w_n1;
    logic signed [CNT_W-1:0] w_n0;
    logic signed [CNT_W-1:0] w_n1_m_n0;
    logic signed [CNT_W-1:0] w_n0_m_n1;
    logic                    w_cnt_zero;
    logic                    w_cnt_neg;
    logic                    w_cnt_pos;
    logic [9:0]              w_sym;
    logic signed [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_qm_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_qm_ones = w_qm_ones + {3'b000, r_s1_qm[i]};
        end
        w_n1       = $signed({{(CNT_W-4){1'b0}}, w_qm_ones});
        w_n0       = c_EIGHT - w_n1;
        w_n1_m_n0  = w_n1 - w_n0;
        w_n0_m_n1  = w_n0 - w_n1;
        w_cnt_zero = (r_cnt == '0);
        w_cnt_neg  = r_cnt[CNT_W-1];
        w_cnt_pos  = !w_cnt_zero && !w_cnt_neg;

        w_sym      = '0;
        w_cnt_next = r_cnt;
        if (!r_s1_ve) begin
            // Blanking restarts disparity tracking from zero.
            w_cnt_next = '0;
            case (r_s1_ctrl)
                2'b00:   w_sym = c_CTRL_00;
                2'b01:   w_sym = c_CTRL_01;
                2'b10:   w_sym = c_CTRL_10;
                default: w_sym = c_CTRL_11;
            endcase
        end else if (w_cnt_zero || (w_n1 == w_n0)) begin
            w_sym      = {~r_s1_qm[8], r_s1_qm[8],
                          r_s1_qm[8] ? r_s1_qm[7:0] : ~r_s1_qm[7:0]};
            w_cnt_next = r_cnt + (r_s1_qm[8] ? w_n1_m_n0 : w_n0_m_n1);
        end else if ((w_cnt_pos && (w_n1 > w_n0)) || (w_cnt_neg && (w_n0 > w_n1))) begin
            // Payload already leans the same way as the running disparity:
            // invert it to pull the line back towards balance.
            w_sym      = {1'b1, r_s1_qm[8], ~r_s1_qm[7:0]};
            w_cnt_next = r_cnt + (r_s1_qm[8] ? c_TWO : '0) + w_n0_m_n1;
        end else begin
            w_sym      = {1'b0, r_s1_qm[8], r_s1_qm[7:0]};
            w_cnt_next = r_cnt - (r_s1_qm[8] ? '0 : c_TWO) + w_n1_m_n0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tmds <= '0;
            r_cnt  <= '0;
        end else if (r_s1_valid) begin
            r_tmds <= w_sym;
            r_cnt  <= w_cnt_next;
        end
    end

    assign tmds_out = r_tmds;

endmodule
`default_nettype wire

// File: tb/tb_tmds_dc_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmds_dc_encoder
//  Purpose  : Self-checking bench for tmds_dc_encoder: reset/latency, a table
//             of hand-computed vectors, mid-operation reset and a random soak
//             against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_dc_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ve;
    logic [9:0] tmds;

    tmds_dc_encoder #(.CNT_W(5)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .data_in    (data),
        .control_in (ctrl),
        .ve_in      (ve),
        .tmds_out   (tmds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input int val);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: value %0d out of range", name, val);
        end
    endtask

    function automatic int dut_cnt();
        return int'(dut.r_cnt);
    endfunction

    // ------------------------------------------------------------------
    // Reference model (integer disparity)
    // ------------------------------------------------------------------
    int m_cnt;

    task automatic model_step(input logic v, input logic [1:0] c, input logic [7:0] d,
                              output logic [9:0] sym);
        int         n1d, n1, n0;
        bit         xn;
        logic [8:0] qm;
        if (!v) begin
            m_cnt = 0;
            case (c)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
        end else begin
            n1d   = $countones(d);
            xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = !xn;
            n1 = $countones(qm[7:0]);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                sym   = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                sym   = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? 2 : 0) + n0 - n1;
            end else begin
                sym   = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? 0 : -2) + n1 - n0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Hand-computed vector table (applied in order from cnt=0)
    // ------------------------------------------------------------------
    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [7:0] d;
        logic [9:0] exp_sym;
        int         exp_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vt[NV];

    logic [9:0] q_sym[$];
    int         q_cnt[$];

    initial begin
        logic [9:0] s;
        int         ac;

        vt[0]  = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vt[1]  = '{1'b1, 2'b00, 8'h00, 10'h3FF,  2};
        vt[2]  = '{1'b1, 2'b00, 8'h00, 10'h100, -6};
        vt[3]  = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vt[4]  = '{1'b0, 2'b01, 8'h00, 10'h0AB,  0};
        vt[5]  = '{1'b0, 2'b10, 8'h00, 10'h154,  0};
        vt[6]  = '{1'b0, 2'b11, 8'h00, 10'h2AB,  0};
        vt[7]  = '{1'b1, 2'b00, 8'hFF, 10'h200, -8};
        vt[8]  = '{1'b1, 2'b00, 8'hFF, 10'h0FF, -2};
        vt[9]  = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vt[10] = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vt[11] = '{1'b0, 2'b01, 8'h00, 10'h0AB,  0};
        vt[12] = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vt[13] = '{1'b1, 2'b00, 8'h0F, 10'h3FA, -2};
        vt[14] = '{1'b1, 2'b00, 8'h10, 10'h1F0, -2};
        vt[15] = '{1'b1, 2'b00, 8'h55, 10'h133, -2};
        vt[16] = '{1'b1, 2'b00, 8'hAA, 10'h233, -2};
        vt[17] = '{1'b1, 2'b00, 8'h01, 10'h1FF,  6};
        vt[18] = '{1'b1, 2'b00, 8'h01, 10'h300,  0};
        vt[19] = '{1'b0, 2'b10, 8'h00, 10'h154,  0};

        // ---------------- reset and latency ----------------
        rst_n = 1'b0; ve = 1'b1; data = 8'h00; ctrl = 2'b00;
        #1;
        check_sym("reset_async_out", tmds, 10'h000);
        repeat (2) @(negedge clk);
        check_sym("reset_held_out", tmds, 10'h000);
        check_int("reset_cnt", dut_cnt(), 0);
        rst_n = 1'b1;                     // first sample at the next posedge
        @(negedge clk);
        check_sym("latency_one_edge", tmds, 10'h000);
        @(negedge clk);
        check_sym("latency_two_edges", tmds, 10'h100);
        check_int("latency_cnt", dut_cnt(), -8);
        @(negedge clk);
        check_sym("zeros_second", tmds, 10'h3FF);

        // ---------------- mid-operation asynchronous reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check_sym("midop_reset_out", tmds, 10'h000);
        check_int("midop_reset_cnt", dut_cnt(), 0);

        // ---------------- table-driven vectors ----------------
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NV + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 2) begin
                check_sym($sformatf("vec%0d_sym", k - 2), tmds, vt[k-2].exp_sym);
                check_int($sformatf("vec%0d_cnt", k - 2), dut_cnt(), vt[k-2].exp_cnt);
            end
            if (k < NV) begin
                ve = vt[k].v; ctrl = vt[k].c; data = vt[k].d;
            end
        end

        // ---------------- random soak ----------------
        // Inputs still hold the last (control) vector, so the pipeline and
        // the model both sit at cnt=0 here.
        m_cnt = 0;
        for (int k = 0; k < 10000 + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check_sym("soak_sym", tmds, q_sym.pop_front());
                ac = dut_cnt();
                check_int("soak_cnt", ac, q_cnt.pop_front());
                check_true("soak_cnt_bound", (ac >= -10) && (ac <= 10), ac);
            end
            if (k < 10000) begin
                ve   = ($urandom_range(0, 7) != 0);
                ctrl = 2'($urandom_range(0, 3));
                data = 8'($urandom_range(0, 255));
                model_step(ve, ctrl, data, s);
                q_sym.push_back(s);
                q_cnt.push_back(m_cnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
